freq_meter: RTL

Gated edge-counting frequency meter. It measures an externally looped-back generator output (square/pulse output or comparator-squared analog output) and reports frequency in Hz, the same unit the sweep path writes into `current_freq`. It lets the UI and self-test logic read back what the generator is actually producing, including the 3 MHz pulse mode. It sits beside the sweep controller and DDS, on the same 100 MHz clock.

---
 rtl/wavegen_pkg.sv | 36 +++
 rtl/freq_meter_if.sv | 21 ++
 rtl/sync_edge_det.sv | 27 ++
 rtl/freq_meter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wavegen_pkg.sv
// Shared definitions for the waveform generator measurement, sweep and display logic.
package wavegen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_SCALE  = 2'd2,
        ST_REPORT = 2'd3
    } fm_state_t;

    localparam int unsigned DEF_CLK_HZ = 100_000_000;
    localparam int unsigned DEF_CNT_W  = 22;
    localparam int unsigned MS_CYCLES  = DEF_CLK_HZ / 1000;
    localparam int unsigned FREQ_MAX   = (1 << DEF_CNT_W) - 1;

    // Hz-per-edge multiplier for each gate_sel code
    localparam int unsigned GATE_MULT_1MS   = 1000;
    localparam int unsigned GATE_MULT_10MS  = 100;
    localparam int unsigned GATE_MULT_100MS = 10;
    localparam int unsigned GATE_MULT_1S    = 1;

    function automatic int unsigned gate_mult(input logic [1:0] sel);
        case (sel)
            2'b00:   return GATE_MULT_1MS;
            2'b01:   return GATE_MULT_10MS;
            2'b10:   return GATE_MULT_100MS;
            default: return GATE_MULT_1S;
        endcase
    endfunction

    // Gate length in clock cycles for a given 1 ms cycle count
    function automatic int unsigned gate_cycles(input int unsigned ms, input logic [1:0] sel);
        return ms * (1000 / gate_mult(sel));
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle between the frequency meter and its host (UI or self-test).
interface freq_meter_if #(
    parameter int unsigned CNT_W = 22
);
    logic             enable;
    logic [1:0]       gate_sel;
    logic [CNT_W-1:0] meas_freq;
    logic             meas_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output enable, gate_sel,
        input  meas_freq, meas_valid, overflow, busy
    );

    modport slave (
        input  enable, gate_sel,
        output meas_freq, meas_valid, overflow, busy
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge pulse; usable for any async input.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // synchronizer chain plus one history register for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter reporting in Hz.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | waiting for enable
// ST_GATE   | counting rising edges for N cycles of the latched gate
// ST_SCALE  | edge count times Hz-per-edge, saturate on overflow
// ST_REPORT | publish result, pulse meas_valid, restart or stop
module freq_meter
    import wavegen_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    freq_meter_if.slave bus
);
    localparam int unsigned MS     = CLK_HZ / 1000;
    localparam int unsigned GATE_W = $clog2(gate_cycles(MS, 2'b11) + 1);
    localparam int unsigned PW     = CNT_W + 10;

    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [GATE_W-1:0] LAST_0  = GATE_W'(gate_cycles(MS, 2'b00) - 1);
    localparam logic [GATE_W-1:0] LAST_1  = GATE_W'(gate_cycles(MS, 2'b01) - 1);
    localparam logic [GATE_W-1:0] LAST_2  = GATE_W'(gate_cycles(MS, 2'b10) - 1);
    localparam logic [GATE_W-1:0] LAST_3  = GATE_W'(gate_cycles(MS, 2'b11) - 1);

    fm_state_t         state;
    fm_state_t         state_next;
    logic              load_gate;
    logic              sig_rise;
    logic [1:0]        gate_sel_q;
    logic [GATE_W-1:0] gate_cnt;
    logic [GATE_W-1:0] gate_last;
    logic [CNT_W-1:0]  edge_cnt;
    logic              edge_sat;
    logic [PW-1:0]     edge_ext;
    logic [PW-1:0]     product;
    logic              scale_ovf;
    logic [CNT_W-1:0]  scale_res;
    logic [CNT_W-1:0]  res_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  meas_freq_q;
    logic              meas_valid_q;
    logic              overflow_q;
    logic              busy_q;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .rise  (sig_rise)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; dropping enable before REPORT abandons the measurement
    always_comb begin
        state_next = state;
        load_gate  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_next = ST_GATE;
                    load_gate  = 1'b1;
                end
            end
            ST_GATE: begin
                if (!bus.enable) begin
                    state_next = ST_IDLE;
                end else if (gate_cnt == gate_last) begin
                    state_next = ST_SCALE;
                end
            end
            ST_SCALE: begin
                state_next = bus.enable ? ST_REPORT : ST_IDLE;
            end
            ST_REPORT: begin
                if (bus.enable) begin
                    state_next = ST_GATE;
                    load_gate  = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // terminal gate count for the latched gate selection
    always_comb begin
        gate_last = LAST_0;
        case (gate_sel_q)
            2'b00:   gate_last = LAST_0;
            2'b01:   gate_last = LAST_1;
            2'b10:   gate_last = LAST_2;
            default: gate_last = LAST_3;
        endcase
    end

    // gate and edge counters; gate_sel is only sampled when a gate starts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_sel_q <= 2'b00;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            edge_sat   <= 1'b0;
        end else if (load_gate) begin
            gate_sel_q <= bus.gate_sel;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            edge_sat   <= 1'b0;
        end else if (state == ST_GATE) begin
            gate_cnt <= gate_cnt + 1'b1;
            if (sig_rise) begin
                if (edge_cnt == CNT_MAX) begin
                    edge_sat <= 1'b1;
                end else begin
                    edge_cnt <= edge_cnt + 1'b1;
                end
            end
        end
    end

    // edge count to Hz by constant shift-add (x1000 = x1024 - x16 - x8)
    always_comb begin
        edge_ext = PW'(edge_cnt);
        product  = edge_ext;
        case (gate_sel_q)
            2'b00:   product = (edge_ext << 10) - (edge_ext << 4) - (edge_ext << 3);
            2'b01:   product = (edge_ext << 6) + (edge_ext << 5) + (edge_ext << 2);
            2'b10:   product = (edge_ext << 3) + (edge_ext << 1);
            default: product = edge_ext;
        endcase
        scale_ovf = edge_sat || (product > PW'(CNT_MAX));
        scale_res = scale_ovf ? CNT_MAX : product[CNT_W-1:0];
    end

    // hold the scaled result for the REPORT cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else if (state == ST_SCALE) begin
            res_q <= scale_res;
            ovf_q <= scale_ovf;
        end
    end

    // published outputs; busy tracks the state being entered so it matches state != IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meas_freq_q  <= '0;
            overflow_q   <= 1'b0;
            meas_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            busy_q       <= (state_next != ST_IDLE);
            if (state == ST_REPORT) begin
                meas_freq_q  <= res_q;
                overflow_q   <= ovf_q;
                meas_valid_q <= 1'b1;
            end
        end
    end

    assign bus.meas_freq  = meas_freq_q;
    assign bus.overflow   = overflow_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.busy       = busy_q;

endmodule
